// File: rtl/demux_bin_reg.sv
// Registered 1-to-N demultiplexer: routes word_in to the channel named by selector,
// with a per-channel valid/ready handshake and a sticky out-of-range flag.
module demux_bin_reg #(
    parameter  int unsigned WORD_WIDTH   = 8,
    parameter  int unsigned ADDR_WIDTH   = 3,
    parameter  int unsigned OUTPUT_COUNT = 5,
    localparam int unsigned TOTAL_WIDTH  = WORD_WIDTH * OUTPUT_COUNT
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [ADDR_WIDTH-1:0]   selector,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    output logic [TOTAL_WIDTH-1:0]  words_out,
    output logic [OUTPUT_COUNT-1:0] words_out_valid,
    input  logic [OUTPUT_COUNT-1:0] words_out_ready,
    output logic                    error_range
);

    logic [TOTAL_WIDTH-1:0]  data_q  = '0;
    logic [OUTPUT_COUNT-1:0] valid_q = '0;
    logic                    err_q   = 1'b0;

    logic [TOTAL_WIDTH-1:0]  data_d;
    logic [OUTPUT_COUNT-1:0] valid_d;
    logic                    err_d;

    logic [OUTPUT_COUNT-1:0] sel_hit;
    logic                    in_range;
    logic                    in_xfer;

    // One-hot decode of the selector; all-zero when it names no channel.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < int'(OUTPUT_COUNT); k++) begin
            sel_hit[k] = (32'(selector) == 32'(k));
        end
        in_range = |sel_hit;
    end

    // Out-of-range words are always taken (and dropped); in-range words wait on their channel.
    assign word_in_ready = !in_range || (|(sel_hit & (~valid_q | words_out_ready)));
    assign in_xfer       = word_in_valid && word_in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~words_out_ready;
        err_d   = err_q;
        if (in_xfer) begin
            if (in_range) begin
                for (int k = 0; k < int'(OUTPUT_COUNT); k++) begin
                    if (sel_hit[k]) begin
                        data_d[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
                    end
                end
                valid_d = valid_d | sel_hit;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign words_out       = data_q;
    assign words_out_valid = valid_q;
    assign error_range     = err_q;

endmodule
